// File: rtl/mem_requester.sv
// ============================================================================
//  Module      : mem_requester
//  Description : Initiator for one main-memory port. Takes single load/store
//                requests, drives aligned memory strobes and returns
//                lane-extracted, extended load data over a response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_requester #(
    parameter  int CAPACITY_BYTES = 128,
    parameter  int BYTES_PER_WORD = 4,
    parameter  int READ_LATENCY   = 1,
    localparam int ADDR_BITS      = $clog2(CAPACITY_BYTES),
    localparam int WORD_BITS      = BYTES_PER_WORD * 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [ADDR_BITS-1:0]      req_address,
    input  logic [WORD_BITS-1:0]      req_wr_data,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [WORD_BITS-1:0]      resp_rd_data,
    output logic                      resp_error,
    output logic [ADDR_BITS-1:0]      mem_address,
    output logic                      mem_rd_en,
    output logic [WORD_BITS-1:0]      mem_wr_data,
    output logic [BYTES_PER_WORD-1:0] mem_wr_en,
    input  logic [WORD_BITS-1:0]      mem_rd_data
);

    localparam int       c_CNT_BITS = 3;
    localparam bit [1:0] c_SZ_BYTE  = 2'b00;
    localparam bit [1:0] c_SZ_HALF  = 2'b01;
    localparam bit [1:0] c_SZ_WORD  = 2'b10;
    localparam bit [1:0] c_SZ_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [c_CNT_BITS-1:0]     r_cnt, w_cnt_nxt;
    logic                      r_write, w_write_nxt;
    logic                      r_unsigned, w_unsigned_nxt;
    logic [1:0]                r_size, w_size_nxt;
    logic [1:0]                r_lane, w_lane_nxt;

    logic                      r_req_ready, w_req_ready_nxt;
    logic                      r_resp_valid, w_resp_valid_nxt;
    logic [WORD_BITS-1:0]      r_resp_rd_data, w_resp_rd_data_nxt;
    logic                      r_resp_error, w_resp_error_nxt;
    logic [ADDR_BITS-1:0]      r_mem_address, w_mem_address_nxt;
    logic                      r_mem_rd_en, w_mem_rd_en_nxt;
    logic [WORD_BITS-1:0]      r_mem_wr_data, w_mem_wr_data_nxt;
    logic [BYTES_PER_WORD-1:0] r_mem_wr_en, w_mem_wr_en_nxt;

    logic                      w_req_err;
    logic [BYTES_PER_WORD-1:0] w_req_be;
    logic [WORD_BITS-1:0]      w_req_wdata;
    logic [WORD_BITS-1:0]      w_rd_shifted;
    logic [WORD_BITS-1:0]      w_rd_extended;

    // Request decode: alignment/size check, byte enables, lane replication
    always_comb begin
        w_req_err   = 1'b0;
        w_req_be    = '0;
        w_req_wdata = req_wr_data;
        case (req_size)
            c_SZ_BYTE: begin
                w_req_be    = BYTES_PER_WORD'(4'b0001 << req_address[1:0]);
                w_req_wdata = {4{req_wr_data[7:0]}};
            end
            c_SZ_HALF: begin
                w_req_err   = req_address[0];
                w_req_be    = BYTES_PER_WORD'(4'b0011 << req_address[1:0]);
                w_req_wdata = {2{req_wr_data[15:0]}};
            end
            c_SZ_WORD: begin
                w_req_err   = (req_address[1:0] != 2'b00);
                w_req_be    = '1;
                w_req_wdata = req_wr_data;
            end
            c_SZ_RSVD: begin
                w_req_err   = 1'b1;
            end
            default: begin
                w_req_err   = 1'b1;
            end
        endcase
    end

    // Load data: move the addressed lane to bit 0, then mask and extend
    always_comb begin
        w_rd_shifted  = mem_rd_data >> {r_lane, 3'b000};
        w_rd_extended = w_rd_shifted;
        case (r_size)
            c_SZ_BYTE: w_rd_extended = {{(WORD_BITS-8){~r_unsigned & w_rd_shifted[7]}},
                                        w_rd_shifted[7:0]};
            c_SZ_HALF: w_rd_extended = {{(WORD_BITS-16){~r_unsigned & w_rd_shifted[15]}},
                                        w_rd_shifted[15:0]};
            default:   w_rd_extended = w_rd_shifted;
        endcase
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_write_nxt        = r_write;
        w_unsigned_nxt     = r_unsigned;
        w_size_nxt         = r_size;
        w_lane_nxt         = r_lane;
        w_req_ready_nxt    = 1'b0;
        w_resp_valid_nxt   = 1'b0;
        w_resp_rd_data_nxt = r_resp_rd_data;
        w_resp_error_nxt   = r_resp_error;
        w_mem_address_nxt  = r_mem_address;
        w_mem_rd_en_nxt    = 1'b0;
        w_mem_wr_data_nxt  = r_mem_wr_data;
        w_mem_wr_en_nxt    = '0;

        case (r_state)
            S_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_req_ready_nxt = 1'b0;
                    w_write_nxt     = req_write;
                    w_unsigned_nxt  = req_unsigned;
                    w_size_nxt      = req_size;
                    w_lane_nxt      = req_address[1:0];
                    if (w_req_err) begin
                        // Rejected requests never touch memory
                        w_state_nxt        = S_RESP;
                        w_resp_valid_nxt   = 1'b1;
                        w_resp_error_nxt   = 1'b1;
                        w_resp_rd_data_nxt = '0;
                    end else begin
                        w_state_nxt       = S_ISSUE;
                        w_mem_address_nxt = {req_address[ADDR_BITS-1:2], 2'b00};
                        w_mem_rd_en_nxt   = ~req_write;
                        w_mem_wr_en_nxt   = req_write ? w_req_be : '0;
                        w_mem_wr_data_nxt = w_req_wdata;
                    end
                end
            end
            S_ISSUE: begin
                if (r_write) begin
                    w_state_nxt        = S_RESP;
                    w_resp_valid_nxt   = 1'b1;
                    w_resp_error_nxt   = 1'b0;
                    w_resp_rd_data_nxt = '0;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = c_CNT_BITS'(READ_LATENCY);
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == c_CNT_BITS'(1)) begin
                    w_state_nxt        = S_RESP;
                    w_resp_valid_nxt   = 1'b1;
                    w_resp_error_nxt   = 1'b0;
                    w_resp_rd_data_nxt = w_rd_extended;
                end
            end
            S_RESP: begin
                w_resp_valid_nxt = 1'b1;
                if (resp_ready) begin
                    w_state_nxt        = S_IDLE;
                    w_resp_valid_nxt   = 1'b0;
                    w_req_ready_nxt    = 1'b1;
                    w_resp_rd_data_nxt = '0;
                    w_resp_error_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_write        <= 1'b0;
            r_unsigned     <= 1'b0;
            r_size         <= 2'b00;
            r_lane         <= 2'b00;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_rd_data <= '0;
            r_resp_error   <= 1'b0;
            r_mem_address  <= '0;
            r_mem_rd_en    <= 1'b0;
            r_mem_wr_data  <= '0;
            r_mem_wr_en    <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_write        <= w_write_nxt;
            r_unsigned     <= w_unsigned_nxt;
            r_size         <= w_size_nxt;
            r_lane         <= w_lane_nxt;
            r_req_ready    <= w_req_ready_nxt;
            r_resp_valid   <= w_resp_valid_nxt;
            r_resp_rd_data <= w_resp_rd_data_nxt;
            r_resp_error   <= w_resp_error_nxt;
            r_mem_address  <= w_mem_address_nxt;
            r_mem_rd_en    <= w_mem_rd_en_nxt;
            r_mem_wr_data  <= w_mem_wr_data_nxt;
            r_mem_wr_en    <= w_mem_wr_en_nxt;
        end
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_rd_data = r_resp_rd_data;
    assign resp_error   = r_resp_error;
    assign mem_address  = r_mem_address;
    assign mem_rd_en    = r_mem_rd_en;
    assign mem_wr_data  = r_mem_wr_data;
    assign mem_wr_en    = r_mem_wr_en;

endmodule

`default_nettype wire

// File: tb/tb_mem_requester.sv
// ============================================================================
//  Module      : tb_mem_requester
//  Description : Scoreboard bench for mem_requester; one instance with read
//                latency 1 and one with read latency 3, each with a memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_write    [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [6:0]  req_address  [2];
    logic [31:0] req_wr_data  [2];
    logic        resp_valid   [2];
    logic        resp_ready   [2];
    logic [31:0] resp_rd_data [2];
    logic        resp_error   [2];
    logic [6:0]  mem_address  [2];
    logic        mem_rd_en    [2];
    logic [31:0] mem_wr_data  [2];
    logic [3:0]  mem_wr_en    [2];
    logic [31:0] mem_rd_data  [2];

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];

    always #5 clk = ~clk;

    mem_requester #(.CAPACITY_BYTES(128), .BYTES_PER_WORD(4), .READ_LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_address(req_address[0]),
        .req_wr_data(req_wr_data[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rd_data(resp_rd_data[0]), .resp_error(resp_error[0]), .mem_address(mem_address[0]),
        .mem_rd_en(mem_rd_en[0]), .mem_wr_data(mem_wr_data[0]), .mem_wr_en(mem_wr_en[0]),
        .mem_rd_data(mem_rd_data[0])
    );

    mem_requester #(.CAPACITY_BYTES(128), .BYTES_PER_WORD(4), .READ_LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_address(req_address[1]),
        .req_wr_data(req_wr_data[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rd_data(resp_rd_data[1]), .resp_error(resp_error[1]), .mem_address(mem_address[1]),
        .mem_rd_en(mem_rd_en[1]), .mem_wr_data(mem_wr_data[1]), .mem_wr_en(mem_wr_en[1]),
        .mem_rd_data(mem_rd_data[1])
    );

    // Memory models: synchronous read with latency 1 and 3; random data
    // whenever the read pipeline does not hold a valid word.
    logic [31:0] mem   [2][32];
    logic [31:0] pd    [2][3];
    logic [2:0]  pv    [2] = '{default: 3'b000};
    logic [31:0] garb  = 32'h0;

    always @(posedge clk) begin
        garb <= $urandom;
        for (int d = 0; d < 2; d++) begin
            pv[d]    <= {pv[d][1:0], mem_rd_en[d]};
            pd[d][0] <= mem[d][mem_address[d][6:2]];
            pd[d][1] <= pd[d][0];
            pd[d][2] <= pd[d][1];
            for (int b = 0; b < 4; b++)
                if (mem_wr_en[d][b])
                    mem[d][mem_address[d][6:2]][b*8 +: 8] <= mem_wr_data[d][b*8 +: 8];
        end
    end

    always_comb begin
        mem_rd_data[0] = pv[0][0] ? pd[0][0] : garb;
        mem_rd_data[1] = pv[1][2] ? pd[1][2] : garb;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: compares whenever a response handshake is present
    always begin
        @(negedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            if (resp_valid[d] && resp_ready[d]) begin
                logic [32:0] e;
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    chk($sformatf("resp%0d_unexpected", d), 32'd1, 32'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("resp%0d_data", d), resp_rd_data[d], e[32:1]);
                    chk($sformatf("resp%0d_err", d), {31'd0, resp_error[d]}, {31'd0, e[0]});
                end
            end
        end
    end

    task automatic drive(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [6:0] addr, input logic [31:0] wd);
        req_write[d]    = wr;
        req_size[d]     = sz;
        req_unsigned[d] = uns;
        req_address[d]  = addr;
        req_wr_data[d]  = wd;
        req_valid[d]    = 1'b1;
    endtask

    // One request with resp_ready held high; cycle 1 is the cycle after acceptance
    task automatic txn(input int d, input string nm, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [6:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                       input logic [3:0] exp_we, input logic [31:0] exp_wd);
        int resp_cyc = -1;
        int rd_n = 0;
        int rd_c = -1;
        int we_n = 0;
        logic [3:0]  we_s = 4'h0;
        logic [31:0] wd_s = 32'h0;
        logic [6:0]  ad_s = 7'h0;
        if (d == 0) q0.push_back({exp_d, exp_e});
        else        q1.push_back({exp_d, exp_e});
        @(negedge clk);
        chk({nm, "_req_ready"}, {31'd0, req_ready[d]}, 32'd1);
        drive(d, wr, sz, uns, addr, wd);
        @(negedge clk);
        req_valid[d] = 1'b0;
        for (int c = 1; c <= 12 && resp_cyc < 0; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_rd_en[d]) begin
                rd_n++; rd_c = c; ad_s = mem_address[d];
            end
            if (mem_wr_en[d] != 4'h0) begin
                we_n++; we_s = mem_wr_en[d]; wd_s = mem_wr_data[d]; ad_s = mem_address[d];
            end
            if (resp_valid[d]) resp_cyc = c;
        end
        chk({nm, "_latency"}, resp_cyc, exp_lat);
        if (exp_e) begin
            chk({nm, "_no_rd_en"}, rd_n, 0);
            chk({nm, "_no_wr_en"}, we_n, 0);
        end else if (wr) begin
            chk({nm, "_wr_en_count"}, we_n, 1);
            chk({nm, "_wr_en"}, {28'd0, we_s}, {28'd0, exp_we});
            chk({nm, "_wr_data"}, wd_s, exp_wd);
            chk({nm, "_mem_addr"}, {25'd0, ad_s}, {25'd0, addr & 7'h7C});
            chk({nm, "_no_rd_en"}, rd_n, 0);
        end else begin
            chk({nm, "_rd_en_count"}, rd_n, 1);
            chk({nm, "_rd_en_cycle"}, rd_c, 1);
            chk({nm, "_mem_addr"}, {25'd0, ad_s}, {25'd0, addr & 7'h7C});
            chk({nm, "_no_wr_en"}, we_n, 0);
        end
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'b00;
            req_unsigned[d] = 1'b0; req_address[d] = 7'h0; req_wr_data[d] = 32'h0;
            resp_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  {31'd0, req_ready[0]},  32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("rst_rd_en",      {31'd0, mem_rd_en[0]},  32'd0);
        chk("rst_wr_en",      {28'd0, mem_wr_en[0]},  32'd0);
        chk("rst_resp_data",  resp_rd_data[0],        32'd0);
        chk("rst_resp_err",   {31'd0, resp_error[0]}, 32'd0);
        reset = 1'b0;

        // Latency-1 instance: stores 2 cycles, loads 3, errors 1
        txn(0, "st_word",  1'b1, 2'b10, 1'b0, 7'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 4'b1111, 32'hDEADBEEF);
        txn(0, "ld_word",  1'b0, 2'b10, 1'b0, 7'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 4'b0000, 32'h0);
        txn(0, "st_w20",   1'b1, 2'b10, 1'b0, 7'h20, 32'h80FF7F01, 32'h0,        1'b0, 2, 4'b1111, 32'h80FF7F01);
        txn(0, "ld_b23_s", 1'b0, 2'b00, 1'b0, 7'h23, 32'h0,        32'hFFFFFF80, 1'b0, 3, 4'b0000, 32'h0);
        txn(0, "ld_b22_u", 1'b0, 2'b00, 1'b1, 7'h22, 32'h0,        32'h000000FF, 1'b0, 3, 4'b0000, 32'h0);
        txn(0, "ld_b21_s", 1'b0, 2'b00, 1'b0, 7'h21, 32'h0,        32'h0000007F, 1'b0, 3, 4'b0000, 32'h0);
        txn(0, "st_half",  1'b1, 2'b01, 1'b0, 7'h06, 32'h0000ABCD, 32'h0,        1'b0, 2, 4'b1100, 32'hABCDABCD);
        txn(0, "ld_h06_s", 1'b0, 2'b01, 1'b0, 7'h06, 32'h0,        32'hFFFFABCD, 1'b0, 3, 4'b0000, 32'h0);
        txn(0, "ld_top_u", 1'b0, 2'b00, 1'b1, 7'h7F, 32'h0,        32'h0,        1'b0, 3, 4'b0000, 32'h0);
        txn(0, "err_wld",  1'b0, 2'b10, 1'b0, 7'h02, 32'h0,        32'h0,        1'b1, 1, 4'b0000, 32'h0);
        txn(0, "err_hst",  1'b1, 2'b01, 1'b0, 7'h01, 32'h1234,     32'h0,        1'b1, 1, 4'b0000, 32'h0);
        txn(0, "err_rsvd", 1'b0, 2'b11, 1'b0, 7'h00, 32'h0,        32'h0,        1'b1, 1, 4'b0000, 32'h0);

        // Latency-3 instance: data must come from the 3-cycle-old read
        txn(1, "l3_st",    1'b1, 2'b10, 1'b0, 7'h10, 32'h12345678, 32'h0,        1'b0, 2, 4'b1111, 32'h12345678);
        txn(1, "l3_ld",    1'b0, 2'b10, 1'b0, 7'h10, 32'h0,        32'h12345678, 1'b0, 5, 4'b0000, 32'h0);
        txn(1, "l3_ld_b",  1'b0, 2'b00, 1'b1, 7'h11, 32'h0,        32'h00000056, 1'b0, 5, 4'b0000, 32'h0);

        // Backpressure on a load, with a competing request held pending
        q0.push_back({32'hDEADBEEF, 1'b0});
        resp_ready[0] = 1'b0;
        @(negedge clk);
        drive(0, 1'b0, 2'b10, 1'b0, 7'h10, 32'h0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        seen = -1;
        for (int c = 1; c <= 10 && seen < 0; c++) begin
            if (c > 1) @(negedge clk);
            if (resp_valid[0]) seen = c;
        end
        chk("bp_latency", seen, 3);
        drive(0, 1'b0, 2'b10, 1'b0, 7'h10, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("bp_valid_%0d", i), {31'd0, resp_valid[0]}, 32'd1);
            chk($sformatf("bp_data_%0d", i),  resp_rd_data[0], 32'hDEADBEEF);
            chk($sformatf("bp_ready_%0d", i), {31'd0, req_ready[0]}, 32'd0);
            chk($sformatf("bp_rd_en_%0d", i), {31'd0, mem_rd_en[0]}, 32'd0);
        end
        resp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_after_hs_ready", {31'd0, req_ready[0]},  32'd1);
        chk("bp_after_hs_valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("bp_after_hs_rd_en", {31'd0, mem_rd_en[0]},  32'd0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("pend_issue_rd_en", {31'd0, mem_rd_en[0]}, 32'd1);

        // Reset while the pending load is waiting for memory
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_req_ready",  {31'd0, req_ready[0]},  32'd1);
        chk("arst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("arst_rd_en",      {31'd0, mem_rd_en[0]},  32'd0);
        chk("arst_wr_en",      {28'd0, mem_wr_en[0]},  32'd0);
        chk("arst_resp_data",  resp_rd_data[0],        32'd0);
        chk("arst_resp_err",   {31'd0, resp_error[0]}, 32'd0);
        chk("arst_mem_addr",   {25'd0, mem_address[0]}, 32'd0);
        chk("arst_wr_data",    mem_wr_data[0],         32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid[0]) seen++;
        end
        chk("arst_no_late_resp", seen, 0);

        repeat (2) @(negedge clk);
        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_requester.md
Name: mem_requester

Overview:
- Initiator side of one main-memory port.
- Accepts single load/store requests from the processor pipeline over a valid/ready handshake.
- Generates word-aligned address, byte-lane write enables and lane-replicated write data. Drives rd_en and waits out the memory's synchronous read latency.
- Returns lane-extracted, sign/zero-extended load data over a valid/ready response channel. One instance per memory port.

Parameters:
- CAPACITY_BYTES, 128, memory size in bytes.
- BYTES_PER_WORD, 4, bytes per memory word. Only 4 is supported.
- READ_LATENCY, 1, cycles from rd_en sampled to mem_rd_data valid. Range 1..4.
- ADDR_BITS, $clog2(CAPACITY_BYTES), derived (localparam).
- WORD_BITS, BYTES_PER_WORD*8, derived (localparam).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
- req_address  in  ADDR_BITS  byte address.
- req_wr_data  in  WORD_BITS  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when high with resp_valid.
- resp_rd_data  out  WORD_BITS  load result; 0 for stores and errors.
- resp_error  out  1  misaligned or reserved-size request.
- mem_address  out  ADDR_BITS  req_address with low 2 bits cleared.
- mem_rd_en  out  1  read strobe.
- mem_wr_data  out  WORD_BITS  lane-replicated store data.
- mem_wr_en  out  BYTES_PER_WORD  byte write enables.
- mem_rd_data  in  WORD_BITS  memory read data.

Behaviour:
- Reset (async assert): state IDLE, latency counter 0. Every output 0 except req_ready=1. In-flight read abandoned and late mem_rd_data ignored. Deassertion releases on the next edge.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs registered.
- IDLE:
  - req_ready=1. Acceptance = req_valid & req_ready at the edge; latch request fields.
  - Error check: size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with resp_error=1, rd_data=0, no memory access.
  - Otherwise -> ISSUE.
- ISSUE (exactly 1 cycle): mem_address valid.
  - Load: mem_rd_en=1, mem_wr_en=0.
  - Store: mem_wr_en = byte 0001<<lane, half 0011<<lane, word 1111, where lane=addr[1:0].
  - Store data: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
  - Next state: load -> WAIT (counter=READ_LATENCY); store -> RESP.
- WAIT: mem_rd_en=0, mem_wr_en=0, counter decrements each cycle.
  - On the cycle counter==1, sample mem_rd_data: shift right by lane*8, mask to size, extend per req_unsigned.
  - Then go to RESP.
- RESP: resp_valid=1 and held stable until resp_ready. On the handshake edge -> IDLE. req_ready stays 0 outside IDLE.
- Latency, with acceptance at edge 0 and READ_LATENCY=L:
  - Load: resp_valid in cycle 2+L.
  - Store: resp_valid in cycle 2.
  - Error: resp_valid in cycle 1.
  - Minimum throughput: load one per 3+L cycles; store one per 3.
- mem_* strobes are never asserted outside ISSUE. mem_address holds its last value in other states.
- Only one outstanding request; no pipelining.
- resp_ready may be held high continuously; response still lasts ≥1 cycle.
- Top address (CAPACITY_BYTES-1, byte load) is legal; no wrap logic needed.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 (L=1):
  - Store: mem_wr_en=1111 in cycle 1; resp_valid cycle 2.
  - Load: mem_rd_en cycle 1; resp_rd_data=0xDEADBEEF in cycle 3, resp_error=0.
- Byte loads from word 0x80FF7F01 @0x20:
  - signed @0x23 -> 0xFFFFFF80.
  - unsigned @0x22 -> 0x000000FF.
  - signed @0x21 -> 0x0000007F.
- Half store 0xABCD @0x06 -> mem_address=0x04, mem_wr_en=1100, mem_wr_data=0xABCDABCD. A following signed half load @0x06 returns 0xFFFFABCD.
- Misaligned and reserved requests -> resp_error=1 in cycle 1, rd_data=0, mem_rd_en/mem_wr_en never asserted:
  - word load @0x02.
  - half store @0x01.
  - size 11.
- Backpressure, then reset mid-read:
  - Hold resp_ready=0 for 5 cycles: resp_valid and data stable, req_ready=0, and a new req_valid is not accepted until 1 cycle after the handshake.
  - Assert reset during WAIT: all outputs 0 immediately (req_ready=1), no resp_valid appears afterwards.
- READ_LATENCY=3 build: word load resp_valid arrives in cycle 5 with the data sampled 3 cycles after rd_en, not earlier. Memory model returns garbage before that.
